// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, select codes,
// ALU commands, condition codes and the data-processing command decode.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        ALU_WB  = 4'd4,
        MEM_ADR = 4'd5,
        MEM_RD  = 4'd6,
        MEM_WB  = 4'd7,
        MEM_WR  = 4'd8,
        BRANCH  = 4'd9
    } state_t;

    // Instruction classes (instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Extend unit selects
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;
    localparam logic [1:0] IMM_SH  = 2'b11;

    // ALU operand and result selects
    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Data-processing commands (funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes (instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // ALU operation for a data-processing command; unknown commands add
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          return ALU_ADD;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

    // True when the command produces a destination write (CMP and unknowns do not)
    function automatic logic cmd_writes(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition-code evaluation: cond field against registered NZCV flags.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Pure combinational lookup; 1111 never executes
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// decodes datapath selects from the state, gates write enables with the
// condition result and holds the NZCV flag register.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctrl,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_req,
    output logic [3:0] flags
);

    state_t     state;
    logic       cond_ex;
    logic       cond_ok;
    logic       imm_flag;
    logic [3:0] cmd;
    logic       sl_bit;

    assign imm_flag = funct[5];
    assign cmd      = funct[4:1];
    assign sl_bit   = funct[0];

    cond_unit u_cond (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // State sequencing, flag register and the condition result latched at
    // decode. Latching keeps the write gating tied to the flags the
    // instruction started with, even after its own S-update in EXEC_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            flags   <= 4'b0000;
            cond_ok <= 1'b0;
        end else begin
            case (state)
                FETCH:   if (mem_ready) state <= DECODE;
                DECODE: begin
                    cond_ok <= cond_ex;
                    case (op)
                        OP_DP:   state <= imm_flag ? EXEC_I : EXEC_R;
                        OP_MEM:  state <= MEM_ADR;
                        OP_BR:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                EXEC_R, EXEC_I: begin
                    if (sl_bit && cond_ok) flags <= alu_flags;
                    state <= ALU_WB;
                end
                ALU_WB:  state <= FETCH;
                MEM_ADR: state <= sl_bit ? MEM_RD : MEM_WR;
                MEM_RD:  if (mem_ready) state <= MEM_WB;
                MEM_WB:  state <= FETCH;
                MEM_WR:  if (mem_ready || !cond_ok) state <= FETCH;
                BRANCH:  state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Moore select decode plus enables gated by condition and mem_ready;
    // while reset is held everything sits at its idle value.
    always_comb begin
        imm_src    = IMM_DP;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_FOUR;
        alu_ctrl   = ALU_ADD;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRCA_PC;
                    result_src = RES_ALURES;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                DECODE: begin
                    alu_src_a  = SRCA_PC;
                    result_src = RES_ALURES;
                end
                EXEC_R: begin
                    alu_src_b = SRCB_REG;
                    imm_src   = IMM_SH;
                    alu_ctrl  = alu_decode(cmd);
                end
                EXEC_I: begin
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_DP;
                    alu_ctrl  = alu_decode(cmd);
                end
                ALU_WB: begin
                    if (cond_ok && cmd_writes(cmd)) begin
                        if (rd == 4'd15) pc_write  = 1'b1;
                        else             reg_write = 1'b1;
                    end
                end
                MEM_ADR: begin
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_MEM;
                end
                MEM_RD: begin
                    adr_src = 1'b1;
                    mem_req = 1'b1;
                end
                MEM_WB: begin
                    result_src = RES_DATA;
                    reg_write  = cond_ok;
                end
                MEM_WR: begin
                    adr_src   = 1'b1;
                    mem_req   = 1'b1;
                    mem_write = cond_ok;
                end
                BRANCH: begin
                    alu_src_a  = SRCA_ALUOUT;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_BR;
                    result_src = RES_ALURES;
                    pc_write   = cond_ok;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each driven cycle pushes the expected
// control word; the monitor pops and compares it at the falling edge.
// Control word: {state, imm_src, src_a, src_b, alu_ctrl, result_src,
//                adr_src, ir_write, pc_write, reg_write, mem_write, mem_req, flags}
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       mem_ready;
    logic [1:0] imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write, mem_req;
    logic [3:0] flags;

    logic [23:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          passed;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cond       (cond),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .imm_src    (imm_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_req    (mem_req),
        .flags      (flags)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] st_act;
    assign st_act = dut.state;

    // expected control word builders
    function automatic logic [23:0] ev(input state_t st, input logic [1:0] imm, a, b, alu, res,
                                       input logic adr, irw, pcw, rw, mw, mreq,
                                       input logic [3:0] fl);
        logic [3:0] s;
        s = st;
        return {s, imm, a, b, alu, res, adr, irw, pcw, rw, mw, mreq, fl};
    endfunction

    function automatic logic [23:0] f_rst();
        return ev(FETCH, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000);
    endfunction
    function automatic logic [23:0] f_fetch(input logic mr, input logic [3:0] fl);
        return ev(FETCH, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 0, mr, mr, 0, 0, 1, fl);
    endfunction
    function automatic logic [23:0] f_dec(input logic [3:0] fl);
        return ev(DECODE, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, fl);
    endfunction
    function automatic logic [23:0] f_exr(input logic [1:0] alu, input logic [3:0] fl);
        return ev(EXEC_R, 2'b11, 2'b00, 2'b00, alu, 2'b00, 0, 0, 0, 0, 0, 0, fl);
    endfunction
    function automatic logic [23:0] f_exi(input logic [1:0] alu, input logic [3:0] fl);
        return ev(EXEC_I, 2'b00, 2'b00, 2'b01, alu, 2'b00, 0, 0, 0, 0, 0, 0, fl);
    endfunction
    function automatic logic [23:0] f_wb(input logic pcw, rw, input logic [3:0] fl);
        return ev(ALU_WB, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, pcw, rw, 0, 0, fl);
    endfunction
    function automatic logic [23:0] f_madr(input logic [3:0] fl);
        return ev(MEM_ADR, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, fl);
    endfunction
    function automatic logic [23:0] f_mrd(input logic [3:0] fl);
        return ev(MEM_RD, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1, fl);
    endfunction
    function automatic logic [23:0] f_mwb(input logic rw, input logic [3:0] fl);
        return ev(MEM_WB, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 0, rw, 0, 0, fl);
    endfunction
    function automatic logic [23:0] f_mwr(input logic mw, input logic [3:0] fl);
        return ev(MEM_WR, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, mw, 1, fl);
    endfunction
    function automatic logic [23:0] f_br(input logic pcw, input logic [3:0] fl);
        return ev(BRANCH, 2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0, pcw, 0, 0, 0, fl);
    endfunction

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        cond = c; op = o; funct = f; rd = r;
    endtask

    task automatic step(input logic mr, input logic [3:0] af,
                        input logic [23:0] e, input string nm);
        mem_ready = mr;
        alu_flags = af;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // asserts reset partway into the cycle; the monitor sees it before the edge
    task automatic step_reset(input string nm);
        mem_ready = 1'b0;
        exp_q.push_back(f_rst());
        name_q.push_back(nm);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    initial begin
        logic [23:0] act;
        logic [23:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {st_act, imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src,
                       adr_src, ir_write, pc_write, reg_write, mem_write, mem_req, flags};
                checks++;
                if (act !== e)
                    $display("FAIL %s: got %06h expected %06h at %0t", nm, act, e, $time);
                else
                    passed++;
            end
        end
    end

    // stimulus
    initial begin
        checks = 0;
        passed = 0;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        alu_flags = 4'b0000;
        set_instr(4'b1110, 2'b00, 6'b000000, 4'd0);
        @(posedge clk);
        #1;

        step(0, 4'b0000, f_rst(), "reset_idle0");
        step(1, 4'b0000, f_rst(), "reset_idle1");
        rst_n = 1'b1;

        // ADD R1,R2,R3: S=0, so alu_flags must not reach the register
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
        step(1, 4'b1111, f_fetch(1, 4'b0000), "add_fetch");
        step(1, 4'b1111, f_dec(4'b0000), "add_decode");
        step(1, 4'b1111, f_exr(2'b00, 4'b0000), "add_exec_r");
        step(1, 4'b1111, f_wb(0, 1, 4'b0000), "add_wb");

        // LDR with two wait cycles in MEM_RD
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd4);
        step(1, 4'b0000, f_fetch(1, 4'b0000), "ldr_fetch");
        step(1, 4'b0000, f_dec(4'b0000), "ldr_decode");
        step(1, 4'b0000, f_madr(4'b0000), "ldr_mem_adr");
        step(0, 4'b0000, f_mrd(4'b0000), "ldr_mem_rd_w0");
        step(0, 4'b0000, f_mrd(4'b0000), "ldr_mem_rd_w1");
        step(1, 4'b0000, f_mrd(4'b0000), "ldr_mem_rd");
        step(1, 4'b0000, f_mwb(1, 4'b0000), "ldr_mem_wb");

        // SUBS R0 sets Z
        set_instr(4'b1110, 2'b00, 6'b000101, 4'd0);
        step(1, 4'b0100, f_fetch(1, 4'b0000), "subs_fetch");
        step(1, 4'b0100, f_dec(4'b0000), "subs_decode");
        step(1, 4'b0100, f_exr(2'b01, 4'b0000), "subs_exec_r");
        step(1, 4'b0100, f_wb(0, 1, 4'b0100), "subs_wb");

        // BEQ taken
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
        step(1, 4'b0000, f_fetch(1, 4'b0100), "beq_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "beq_decode");
        step(1, 4'b0000, f_br(1, 4'b0100), "beq_branch");

        // BNE not taken
        set_instr(4'b0001, 2'b10, 6'b100000, 4'd0);
        step(1, 4'b0000, f_fetch(1, 4'b0100), "bne_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "bne_decode");
        step(1, 4'b0000, f_br(0, 4'b0100), "bne_branch");

        // STRNE with Z=1: no write strobe, no wait on mem_ready
        set_instr(4'b0001, 2'b01, 6'b011000, 4'd2);
        step(1, 4'b0000, f_fetch(1, 4'b0100), "strne_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "strne_decode");
        step(1, 4'b0000, f_madr(4'b0100), "strne_mem_adr");
        step(0, 4'b0000, f_mwr(0, 4'b0100), "strne_mem_wr");

        // STR always, one wait cycle
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd2);
        step(1, 4'b0000, f_fetch(1, 4'b0100), "str_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "str_decode");
        step(1, 4'b0000, f_madr(4'b0100), "str_mem_adr");
        step(0, 4'b0000, f_mwr(1, 4'b0100), "str_mem_wr_wait");
        step(1, 4'b0000, f_mwr(1, 4'b0100), "str_mem_wr");

        // ADD R15 writes the PC instead of the register file
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd15);
        step(1, 4'b0000, f_fetch(1, 4'b0100), "addpc_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "addpc_decode");
        step(1, 4'b0000, f_exr(2'b00, 4'b0100), "addpc_exec_r");
        step(1, 4'b0000, f_wb(1, 0, 4'b0100), "addpc_wb");

        // illegal op returns to FETCH
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd3);
        step(1, 4'b0000, f_fetch(1, 4'b0100), "ill_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "ill_decode");

        // ORR immediate with a fetch stall
        set_instr(4'b1110, 2'b00, 6'b111000, 4'd5);
        step(0, 4'b0000, f_fetch(0, 4'b0100), "orr_fetch_wait");
        step(1, 4'b0000, f_fetch(1, 4'b0100), "orr_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "orr_decode");
        step(1, 4'b0000, f_exi(2'b11, 4'b0100), "orr_exec_i");
        step(1, 4'b0000, f_wb(0, 1, 4'b0100), "orr_wb");

        // AND register
        set_instr(4'b1110, 2'b00, 6'b000000, 4'd6);
        step(1, 4'b0000, f_fetch(1, 4'b0100), "and_fetch");
        step(1, 4'b0000, f_dec(4'b0100), "and_decode");
        step(1, 4'b0000, f_exr(2'b10, 4'b0100), "and_exec_r");
        step(1, 4'b0000, f_wb(0, 1, 4'b0100), "and_wb");

        // CMP: flags update, no register write
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd0);
        step(1, 4'b1000, f_fetch(1, 4'b0100), "cmp_fetch");
        step(1, 4'b1000, f_dec(4'b0100), "cmp_decode");
        step(1, 4'b1000, f_exr(2'b01, 4'b0100), "cmp_exec_r");
        step(1, 4'b1000, f_wb(0, 0, 4'b1000), "cmp_wb");

        // ADDSEQ with Z=0: no write and flags hold
        set_instr(4'b0000, 2'b00, 6'b001001, 4'd7);
        step(1, 4'b0100, f_fetch(1, 4'b1000), "addseq_fetch");
        step(1, 4'b0100, f_dec(4'b1000), "addseq_decode");
        step(1, 4'b0100, f_exr(2'b00, 4'b1000), "addseq_exec_r");
        step(1, 4'b0100, f_wb(0, 0, 4'b1000), "addseq_wb");

        // ADDMI with N=1 executes
        set_instr(4'b0100, 2'b00, 6'b001000, 4'd8);
        step(1, 4'b0000, f_fetch(1, 4'b1000), "addmi_fetch");
        step(1, 4'b0000, f_dec(4'b1000), "addmi_decode");
        step(1, 4'b0000, f_exr(2'b00, 4'b1000), "addmi_exec_r");
        step(1, 4'b0000, f_wb(0, 1, 4'b1000), "addmi_wb");

        // reset in the middle of a load
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd9);
        step(1, 4'b0000, f_fetch(1, 4'b1000), "rldr_fetch");
        step(1, 4'b0000, f_dec(4'b1000), "rldr_decode");
        step(1, 4'b0000, f_madr(4'b1000), "rldr_mem_adr");
        step(0, 4'b0000, f_mrd(4'b1000), "rldr_mem_rd");
        step_reset("rldr_reset_now");
        step(1, 4'b0000, f_rst(), "rldr_reset_hold");
        rst_n = 1'b1;
        step(0, 4'b0000, f_fetch(0, 4'b0000), "post_rst_fetch0");
        step(0, 4'b0000, f_fetch(0, 4'b0000), "post_rst_fetch1");
        step(1, 4'b0000, f_fetch(1, 4'b0000), "post_rst_fetch");
        step(1, 4'b0000, f_dec(4'b0000), "post_rst_decode");
        step(1, 4'b0000, f_madr(4'b0000), "post_rst_mem_adr");
        step(1, 4'b0000, f_mrd(4'b0000), "post_rst_mem_rd");
        step(1, 4'b0000, f_mwb(1, 4'b0000), "post_rst_mem_wb");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
